// File: rtl/cpu_step_ctrl_pkg.sv
// Shared CPU-board definitions: controller state encoding and button bit positions.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STEP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int BTN_STEP = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_HALT = 2;
  localparam int BTN_CLR  = 3;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Board-side signal bundle between the button/switch stage, the step controller and the CPU.
interface cpu_step_ctrl_if;
  import cpu_step_ctrl_pkg::*;

  // No backpressure anywhere: btn_pulse and cpu_en are single-cycle strobes the
  // consumer must take in the cycle they are high; levels are plain registered state.
  logic [3:0]  button_in;
  logic [7:0]  sw_in;
  logic [3:0]  btn_pulse;
  logic        cpu_en;
  logic        mode_run;
  logic        halted;
  logic [15:0] step_count;
  logic [1:0]  disp_sel;
  state_e      state;

  modport slave (
    input  button_in, sw_in,
    output btn_pulse, cpu_en, mode_run, halted, step_count, disp_sel, state
  );

  modport master (
    output button_in, sw_in,
    input  btn_pulse, cpu_en, mode_run, halted, step_count, disp_sel, state
  );

endinterface

// File: rtl/cpu_step_ctrl_btn_edge_det.sv
// Registered rising-edge detector, one pulse per press per bit.
module btn_edge_det #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] pulse_o
);

  logic [W-1:0] prev_q;
  logic [W-1:0] pulse_q;

  // prev resets to all-ones so a button held through reset release stays silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '1;
      pulse_q <= '0;
    end else begin
      prev_q  <= in_i;
      pulse_q <= in_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU single-step / free-run / halt controller with run-mode divider and step counter.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  cpu_step_ctrl_if.slave  bus
);

  localparam logic [31:0] DIV_LAST = 32'(DIV - 1);

  logic [3:0]  btn_pulse;
  logic        step_p, mode_p, halt_p, clr_p;

  state_e      state_q, state_d;
  logic        cpu_en_q, cpu_en_d;
  logic [31:0] div_q, div_d;
  logic [15:0] step_cnt_q, step_cnt_d;
  logic [1:0]  disp_sel_q;
  logic        unused_sw;

  btn_edge_det #(.W(4)) u_edge (
    .clk     (clk),
    .rst     (rst),
    .in_i    (bus.button_in),
    .pulse_o (btn_pulse)
  );

  assign step_p = btn_pulse[BTN_STEP];
  assign mode_p = btn_pulse[BTN_MODE];
  assign halt_p = btn_pulse[BTN_HALT];
  assign clr_p  = btn_pulse[BTN_CLR];

  // Any state change swallows a coincident step or divider pulse; halt beats mode.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    div_d    = '0;
    case (state_q)
      ST_STEP: begin
        if (halt_p)      state_d  = ST_HALT;
        else if (mode_p) state_d  = ST_RUN;
        else if (step_p) cpu_en_d = 1'b1;
      end
      ST_RUN: begin
        if (halt_p)      state_d = ST_HALT;
        else if (mode_p) state_d = ST_STEP;
        else if (div_q == DIV_LAST) cpu_en_d = 1'b1;
        else             div_d   = div_q + 32'd1;
      end
      ST_HALT: begin
        if (halt_p) state_d = ST_STEP;
      end
      default: state_d = ST_STEP;
    endcase
  end

  // Count moves in the same edge that raises cpu_en, so clear+step resolves to zero.
  always_comb begin
    step_cnt_d = step_cnt_q;
    if (clr_p)         step_cnt_d = '0;
    else if (cpu_en_d) step_cnt_d = step_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STEP;
      cpu_en_q   <= 1'b0;
      div_q      <= '0;
      step_cnt_q <= '0;
      disp_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      cpu_en_q   <= cpu_en_d;
      div_q      <= div_d;
      step_cnt_q <= step_cnt_d;
      disp_sel_q <= bus.sw_in[1:0];
    end
  end

  assign unused_sw = ^bus.sw_in[7:2];

  assign bus.btn_pulse  = btn_pulse;
  assign bus.cpu_en     = cpu_en_q;
  assign bus.mode_run   = (state_q == ST_RUN);
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.step_count = step_cnt_q;
  assign bus.disp_sel   = disp_sel_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DIV=8 and hand-computed expectations.
module tb_cpu_step_ctrl;
  import cpu_step_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   en_seen = 0;
  int   pulse_seen = 0;

  cpu_step_ctrl_if bus ();

  cpu_step_ctrl #(.DIV(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick();
      if (bus.cpu_en) en_seen++;
      if (bus.btn_pulse != 4'h0) pulse_seen++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.button_in = 4'h0;
    bus.sw_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    en_seen = 0;
    pulse_seen = 0;
  endtask

  task automatic press(input logic [3:0] b);
    bus.button_in = b;
    tick_n(1);
    bus.button_in = 4'h0;
    tick_n(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.button_in = 4'h0;
    bus.sw_in = 8'hA7;
    tick();
    tick();
    checks++; if (bus.btn_pulse !== 4'h0) begin errors++; $display("FAIL reset_btn_pulse: got %0h expected 0", bus.btn_pulse); end
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %0b expected 0", bus.cpu_en); end
    checks++; if (bus.mode_run !== 1'b0) begin errors++; $display("FAIL reset_mode_run: got %0b expected 0", bus.mode_run); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", bus.halted); end
    checks++; if (bus.step_count !== 16'h0) begin errors++; $display("FAIL reset_step_count: got %0h expected 0", bus.step_count); end
    checks++; if (bus.disp_sel !== 2'b00) begin errors++; $display("FAIL reset_disp_sel: got %0b expected 00", bus.disp_sel); end
    checks++; if (bus.state !== ST_STEP) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.state, ST_STEP); end
  endtask

  task automatic test_step_press();
    int pulses;
    int en_at;
    do_reset();
    pulses = 0;
    en_at = -1;
    bus.button_in = 4'b0001;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.btn_pulse[BTN_STEP]) pulses++;
      if (bus.cpu_en) begin en_seen++; if (en_at < 0) en_at = c; end
      if (c == 20) bus.button_in = 4'b0000;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL step_pulse_count: got %0d expected 1", pulses); end
    checks++; if (en_seen !== 1) begin errors++; $display("FAIL step_en_count: got %0d expected 1", en_seen); end
    checks++; if (en_at !== 2) begin errors++; $display("FAIL step_en_latency: got %0d expected 2", en_at); end
    checks++; if (bus.step_count !== 16'd1) begin errors++; $display("FAIL step_count_one: got %0h expected 1", bus.step_count); end
  endtask

  task automatic test_run_mode();
    int en_t[$];
    logic run_seen;
    do_reset();
    run_seen = 1'b0;
    bus.button_in = 4'b0010;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (bus.cpu_en) en_t.push_back(c);
      if (c == 1) bus.button_in = 4'b0000;
      if (c == 2) run_seen = bus.mode_run;
      if (c == 27) bus.button_in = 4'b0010;
      if (c == 28) bus.button_in = 4'b0000;
    end
    checks++; if (run_seen !== 1'b1) begin errors++; $display("FAIL run_entry: got %0b expected 1", run_seen); end
    checks++; if (en_t.size() !== 3) begin errors++; $display("FAIL run_en_count: got %0d expected 3", en_t.size()); end
    if (en_t.size() >= 3) begin
      checks++; if (en_t[0] !== 10) begin errors++; $display("FAIL run_en_first: got %0d expected 10", en_t[0]); end
      checks++; if (en_t[1] !== 18) begin errors++; $display("FAIL run_en_second: got %0d expected 18", en_t[1]); end
      checks++; if (en_t[2] !== 26) begin errors++; $display("FAIL run_en_third: got %0d expected 26", en_t[2]); end
    end
    checks++; if (bus.mode_run !== 1'b0) begin errors++; $display("FAIL run_exit: got %0b expected 0", bus.mode_run); end
    checks++; if (bus.step_count !== 16'd3) begin errors++; $display("FAIL run_step_count: got %0h expected 3", bus.step_count); end
  endtask

  task automatic test_halt();
    do_reset();
    press(4'b0010);
    checks++; if (bus.mode_run !== 1'b1) begin errors++; $display("FAIL halt_pre_run: got %0b expected 1", bus.mode_run); end
    press(4'b0110);
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_priority_halted: got %0b expected 1", bus.halted); end
    checks++; if (bus.mode_run !== 1'b0) begin errors++; $display("FAIL halt_priority_mode_run: got %0b expected 0", bus.mode_run); end
    tick_n(10);
    press(4'b0001);
    tick_n(4);
    press(4'b0010);
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_ignores_mode: got %0b expected 1", bus.halted); end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL halt_no_cpu_en: got %0d expected 0", en_seen); end
    press(4'b0100);
    checks++; if (bus.state !== ST_STEP) begin errors++; $display("FAIL halt_to_step: got %0d expected %0d", bus.state, ST_STEP); end
    press(4'b0011);
    tick_n(2);
    checks++; if (bus.mode_run !== 1'b1) begin errors++; $display("FAIL step_mode_coincide_state: got %0b expected 1", bus.mode_run); end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL step_mode_coincide_en: got %0d expected 0", en_seen); end
    checks++; if (bus.step_count !== 16'd0) begin errors++; $display("FAIL halt_step_count: got %0h expected 0", bus.step_count); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    press(4'b0001);
    tick_n(1);
    checks++; if (bus.step_count !== 16'd1) begin errors++; $display("FAIL wrap_plain_step: got %0h expected 1", bus.step_count); end
    force dut.step_cnt_q = 16'hFFFF;
    #1;
    release dut.step_cnt_q;
    en_seen = 0;
    press(4'b1001);
    tick_n(1);
    checks++; if (bus.step_count !== 16'h0000) begin errors++; $display("FAIL wrap_clear_and_step: got %0h expected 0", bus.step_count); end
    checks++; if (en_seen !== 1) begin errors++; $display("FAIL wrap_clear_step_en: got %0d expected 1", en_seen); end
    force dut.step_cnt_q = 16'hFFFF;
    #1;
    release dut.step_cnt_q;
    press(4'b0001);
    tick_n(1);
    checks++; if (bus.step_count !== 16'h0000) begin errors++; $display("FAIL wrap_ffff_to_0: got %0h expected 0", bus.step_count); end
    press(4'b1000);
    press(4'b0001);
    press(4'b0001);
    tick_n(1);
    checks++; if (bus.step_count !== 16'd2) begin errors++; $display("FAIL wrap_after_clear: got %0h expected 2", bus.step_count); end
  endtask

  task automatic test_reset_hold();
    rst = 1'b1;
    bus.button_in = 4'b0001;
    bus.sw_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    en_seen = 0;
    pulse_seen = 0;
    tick_n(5);
    checks++; if (pulse_seen !== 0) begin errors++; $display("FAIL hold_through_reset_pulse: got %0d expected 0", pulse_seen); end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL hold_through_reset_en: got %0d expected 0", en_seen); end
    bus.button_in = 4'b0000;
    tick_n(1);
    bus.button_in = 4'b0001;
    tick_n(1);
    checks++; if (bus.btn_pulse !== 4'b0001) begin errors++; $display("FAIL repress_pulse: got %0h expected 1", bus.btn_pulse); end
    bus.button_in = 4'b0000;
    tick_n(2);
    bus.sw_in = 8'hA7;
    press(4'b0010);
    tick_n(5);
    en_seen = 0;
    checks++; if (bus.step_count !== 16'd1 || bus.disp_sel !== 2'b11 || bus.mode_run !== 1'b1)
      begin errors++; $display("FAIL pre_midrun_reset: got cnt=%0h sel=%0b run=%0b expected cnt=1 sel=11 run=1", bus.step_count, bus.disp_sel, bus.mode_run); end
    rst = 1'b1;
    #1;
    checks++; if (bus.step_count !== 16'h0 || bus.disp_sel !== 2'b00 || bus.mode_run !== 1'b0 || bus.halted !== 1'b0 || bus.cpu_en !== 1'b0 || bus.btn_pulse !== 4'h0)
      begin errors++; $display("FAIL midrun_reset_outputs: got cnt=%0h sel=%0b run=%0b halt=%0b en=%0b btn=%0h expected all 0", bus.step_count, bus.disp_sel, bus.mode_run, bus.halted, bus.cpu_en, bus.btn_pulse); end
    checks++; if (bus.state !== ST_STEP) begin errors++; $display("FAIL midrun_reset_state: got %0d expected %0d", bus.state, ST_STEP); end
    tick_n(4);
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL midrun_reset_no_en: got %0d expected 0", en_seen); end
    rst = 1'b0;
    bus.sw_in = 8'h00;
  endtask

  task automatic test_disp_sel();
    state_e exp_st[3];
    exp_st[0] = ST_STEP;
    exp_st[1] = ST_RUN;
    exp_st[2] = ST_HALT;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      if (s == 1) press(4'b0010);
      if (s == 2) press(4'b0100);
      checks++; if (bus.state !== exp_st[s]) begin errors++; $display("FAIL disp_state_%0d: got %0d expected %0d", s, bus.state, exp_st[s]); end
      bus.sw_in = 8'hA7;
      #1;
      checks++; if (bus.disp_sel !== 2'b00) begin errors++; $display("FAIL disp_latency_%0d: got %0b expected 00", s, bus.disp_sel); end
      tick();
      checks++; if (bus.disp_sel !== 2'b11) begin errors++; $display("FAIL disp_follow_%0d: got %0b expected 11", s, bus.disp_sel); end
      bus.sw_in = 8'h5C;
      tick();
      checks++; if (bus.disp_sel !== 2'b00) begin errors++; $display("FAIL disp_back_%0d: got %0b expected 00", s, bus.disp_sel); end
    end
  endtask

  initial begin
    bus.button_in = 4'h0;
    bus.sw_in = 8'h00;
    test_reset();
    test_step_press();
    test_run_mode();
    test_halt();
    test_count_wrap();
    test_reset_hold();
    test_disp_sel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
